// File: rtl/intr_ctrl.sv
// intr_ctrl: programmable interrupt controller driving the CPU's single
// external interrupt line.
//
// Collects N_IRQ asynchronous peripheral requests, synchronizes each one and
// latches it as level- or rising-edge-triggered. The latched requests are
// masked and OR-reduced into the registered o_intr level.
//
// Ports
//   clk           system clock
//   nrst          asynchronous active-low reset
//   i_irq         peripheral requests (async to clk, active-high)
//   o_intr        registered interrupt request to the CPU
//   i_MAddr       bus byte address; bits [3:2] select the register
//   i_MCmd        bus command: 001 write, 010 read, anything else idle
//   i_MData       bus write data (full word)
//   o_SCmdAccept  combinational accept, high for read or write
//   o_SResp       registered response: 01 (DVA) the cycle after accept
//   o_SData       registered read data, 0 unless answering a read
//
// Register map: 0x0 PEND (W1C for edge bits), 0x4 MASK, 0x8 EDGE,
// 0xC VEC (read only: bit31 any active, bits[4:0] lowest active index).
module intr_ctrl #(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_IRQ-1:0] i_irq,
    output logic             o_intr,
    input  logic [31:0]      i_MAddr,
    input  logic [2:0]       i_MCmd,
    input  logic [31:0]      i_MData,
    output logic             o_SCmdAccept,
    output logic [1:0]       o_SResp,
    output logic [31:0]      o_SData
);

    localparam logic [2:0] CMD_WR    = 3'b001;
    localparam logic [2:0] CMD_RD    = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] SEL_PEND  = 2'd0;
    localparam logic [1:0] SEL_MASK  = 2'd1;
    localparam logic [1:0] SEL_EDGE  = 2'd2;
    localparam logic [1:0] SEL_VEC   = 2'd3;

    // Lowest set bit index of v, 0 when v is empty. Scanning from the top
    // down lets the lowest index overwrite any higher one.
    function automatic logic [4:0] lowest_idx(input logic [N_IRQ-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[4:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [N_IRQ-1:0] sync1_r;
    logic [N_IRQ-1:0] sync2_r;
    logic [N_IRQ-1:0] prev_r;
    logic [N_IRQ-1:0] pend_r;
    logic [N_IRQ-1:0] mask_r;
    logic [N_IRQ-1:0] edge_r;
    logic             intr_r;
    logic [1:0]       sresp_r;
    logic [31:0]      sdata_r;

    logic [N_IRQ-1:0] pend_next_s;
    logic [N_IRQ-1:0] active_s;
    logic [N_IRQ-1:0] wdata_s;
    logic [31:0]      rdata_s;
    logic [1:0]       sel_s;
    logic             wr_s;
    logic             rd_s;
    logic             unused_s;

    assign wr_s         = (i_MCmd == CMD_WR);
    assign rd_s         = (i_MCmd == CMD_RD);
    assign o_SCmdAccept = wr_s | rd_s;
    assign sel_s        = i_MAddr[3:2];
    assign wdata_s      = i_MData[N_IRQ-1:0];
    assign active_s     = pend_r & mask_r;
    assign o_intr       = intr_r;
    assign o_SResp      = sresp_r;
    assign o_SData      = sdata_r;
    // Address bits outside [3:2] and write bits above N_IRQ carry no meaning.
    assign unused_s     = ^{i_MAddr[31:4], i_MAddr[1:0], i_MData};

    // Pending next state: level bits mirror sync2, edge bits set on a rising
    // edge and clear on W1C, with a same-cycle edge taking precedence.
    always_comb begin
        pend_next_s = pend_r;
        for (int i = 0; i < N_IRQ; i++) begin
            if (edge_r[i]) begin
                if (sync2_r[i] && !prev_r[i]) begin
                    pend_next_s[i] = 1'b1;
                end else if (wr_s && (sel_s == SEL_PEND) && wdata_s[i]) begin
                    pend_next_s[i] = 1'b0;
                end else begin
                    pend_next_s[i] = pend_r[i];
                end
            end else begin
                pend_next_s[i] = sync2_r[i];
            end
        end
    end

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        rdata_s = 32'd0;
        case (sel_s)
            SEL_PEND: rdata_s[N_IRQ-1:0] = pend_r;
            SEL_MASK: rdata_s[N_IRQ-1:0] = mask_r;
            SEL_EDGE: rdata_s[N_IRQ-1:0] = edge_r;
            SEL_VEC: begin
                rdata_s[31]  = |active_s;
                rdata_s[4:0] = lowest_idx(active_s);
            end
            default: rdata_s = 32'd0;
        endcase
    end

    // Two-flop synchronizer plus the previous-sample register for edge detect.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= i_irq;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // MASK and EDGE configuration registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mask_r <= '0;
            edge_r <= '0;
        end else begin
            if (wr_s && (sel_s == SEL_MASK)) begin
                mask_r <= wdata_s;
            end else begin
                mask_r <= mask_r;
            end
            if (wr_s && (sel_s == SEL_EDGE)) begin
                edge_r <= wdata_s;
            end else begin
                edge_r <= edge_r;
            end
        end
    end

    // Pending register and the interrupt level derived from it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_r <= '0;
            intr_r <= 1'b0;
        end else begin
            pend_r <= pend_next_s;
            intr_r <= |active_s;
        end
    end

    // One DVA per accepted command, read data only for reads.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sresp_r <= RESP_NULL;
            sdata_r <= 32'd0;
        end else begin
            sresp_r <= o_SCmdAccept ? RESP_DVA : RESP_NULL;
            sdata_r <= rd_s ? rdata_s : 32'd0;
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl (N_IRQ = 8): a register/bus vector table,
// hand-written timing sequences, and a randomized run against a queue-based
// reference model.
module tb_intr_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic [N-1:0]  irq;
    logic          intr;
    logic [31:0]   maddr;
    logic [2:0]    mcmd;
    logic [31:0]   mdata;
    logic          accept;
    logic [1:0]    sresp;
    logic [31:0]   sdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intr_ctrl #(.N_IRQ(N)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .i_irq        (irq),
        .o_intr       (intr),
        .i_MAddr      (maddr),
        .i_MCmd       (mcmd),
        .i_MData      (mdata),
        .o_SCmdAccept (accept),
        .o_SResp      (sresp),
        .o_SData      (sdata)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  irq;
        int          settle;
        logic [31:0] exp_data;
        logic        exp_intr;
    } vec_t;

    vec_t tbl[20];

    // reference model state
    bit [7:0] m_pend, m_mask, m_edge;
    bit [7:0] hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        nrst  = 1'b0;
        irq   = '0;
        mcmd  = 3'b000;
        maddr = 32'd0;
        mdata = 32'd0;
        repeat (2) tick;
        nrst = 1'b1;
        tick;
    endtask

    // One bus command followed by an idle cycle; returns data and o_intr
    // sampled in the response cycle.
    task automatic bus_op(input logic [2:0] cmd, input logic [3:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic intr_at);
        logic [1:0] exp_resp;
        exp_resp = (cmd == 3'b001 || cmd == 3'b010) ? 2'b01 : 2'b00;
        mcmd  = cmd;
        maddr = 32'h5A5A_0000 | {28'd0, addr};
        mdata = wd;
        #1;
        check("accept", {31'd0, accept}, {31'd0, exp_resp[0]});
        tick;
        check("resp_cmd", {30'd0, sresp}, {30'd0, exp_resp});
        rd      = sdata;
        intr_at = intr;
        mcmd    = 3'b000;
        tick;
        check("resp_idle", {30'd0, sresp}, 32'd0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic        i;
        bus_op(3'b001, addr, wd, d, i);
        check("wr_sdata", d, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        i;
        bus_op(3'b010, addr, 32'd0, d, i);
        check(name, d, exp);
    endtask

    function automatic bit [31:0] model_read(input bit [1:0] sel);
        bit [7:0] act;
        act = m_pend & m_mask;
        case (sel)
            2'd0: return {24'd0, m_pend};
            2'd1: return {24'd0, m_mask};
            2'd2: return {24'd0, m_edge};
            default: begin
                for (int i = 0; i < N; i++)
                    if (act[i]) return 32'h8000_0000 | i;
                return 32'd0;
            end
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        ia;

        // cmd, addr, wdata, irq, settle, exp_data, exp_intr
        tbl[0]  = '{3'b010, 4'h0, 32'h0,         8'h00, 0, 32'h0,         1'b0};
        tbl[1]  = '{3'b010, 4'h4, 32'h0,         8'h00, 0, 32'h0,         1'b0};
        tbl[2]  = '{3'b010, 4'h8, 32'h0,         8'h00, 0, 32'h0,         1'b0};
        tbl[3]  = '{3'b010, 4'hC, 32'h0,         8'h00, 0, 32'h0,         1'b0};
        tbl[4]  = '{3'b001, 4'h4, 32'hFFFF_FF20, 8'h00, 0, 32'h0,         1'b0};
        tbl[5]  = '{3'b010, 4'h4, 32'h0,         8'h00, 0, 32'h20,        1'b0};
        tbl[6]  = '{3'b010, 4'h0, 32'h0,         8'h30, 4, 32'h30,        1'b1};
        tbl[7]  = '{3'b010, 4'hC, 32'h0,         8'h30, 0, 32'h8000_0005, 1'b1};
        tbl[8]  = '{3'b001, 4'h4, 32'h30,        8'h30, 0, 32'h0,         1'b1};
        tbl[9]  = '{3'b010, 4'hC, 32'h0,         8'h30, 0, 32'h8000_0004, 1'b1};
        tbl[10] = '{3'b001, 4'h4, 32'h0,         8'h30, 0, 32'h0,         1'b1};
        tbl[11] = '{3'b010, 4'hC, 32'h0,         8'h30, 0, 32'h0,         1'b0};
        tbl[12] = '{3'b010, 4'h0, 32'h0,         8'h30, 0, 32'h30,        1'b0};
        tbl[13] = '{3'b001, 4'hC, 32'hFFFF_FFFF, 8'h30, 0, 32'h0,         1'b0};
        tbl[14] = '{3'b010, 4'hC, 32'h0,         8'h30, 0, 32'h0,         1'b0};
        tbl[15] = '{3'b011, 4'h0, 32'h0,         8'h30, 0, 32'h0,         1'b0};
        tbl[16] = '{3'b001, 4'h8, 32'hFFFF_FFFF, 8'h30, 0, 32'h0,         1'b0};
        tbl[17] = '{3'b010, 4'h8, 32'h0,         8'h30, 0, 32'hFF,        1'b0};
        tbl[18] = '{3'b001, 4'h0, 32'hFFFF_FFFF, 8'h30, 0, 32'h0,         1'b0};
        tbl[19] = '{3'b010, 4'h0, 32'h0,         8'h30, 0, 32'h0,         1'b0};

        do_reset;
        check("reset_intr", {31'd0, intr}, 32'd0);
        check("reset_resp", {30'd0, sresp}, 32'd0);
        check("reset_sdata", sdata, 32'd0);

        // table: register behaviour with statically held requests
        for (int k = 0; k < 20; k++) begin
            irq = tbl[k].irq;
            repeat (tbl[k].settle) tick;
            bus_op(tbl[k].cmd, tbl[k].addr, tbl[k].wdata, d, ia);
            check($sformatf("tbl%0d_data", k), d, tbl[k].exp_data);
            check($sformatf("tbl%0d_intr", k), {31'd0, ia}, {31'd0, tbl[k].exp_intr});
        end

        // level source: 4-edge latency in both directions, W1C has no effect
        do_reset;
        wr(4'h4, 32'h04);
        wr(4'h8, 32'h00);
        irq[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check($sformatf("lvl_rise_e%0d", k), {31'd0, intr}, {31'd0, (k == 3)});
        end
        rd_chk("lvl_vec", 4'hC, 32'h8000_0002);
        wr(4'h0, 32'h04);
        rd_chk("lvl_pend_after_w1c", 4'h0, 32'h04);
        irq[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            check($sformatf("lvl_fall_e%0d", k), {31'd0, intr}, {31'd0, (k < 3)});
        end

        // edge source: latch, W1C drops o_intr one cycle later
        do_reset;
        wr(4'h8, 32'h01);
        wr(4'h4, 32'h01);
        irq[0] = 1'b1;
        repeat (3) tick;
        irq[0] = 1'b0;
        repeat (3) tick;
        rd_chk("edge_pend", 4'h0, 32'h01);
        check("edge_intr", {31'd0, intr}, 32'd1);
        bus_op(3'b001, 4'h0, 32'h01, d, ia);
        check("edge_intr_at_w1c", {31'd0, ia}, 32'd1);
        check("edge_intr_after_w1c", {31'd0, intr}, 32'd0);
        // new rising edge lands in the same cycle as a W1C: set wins
        irq[0] = 1'b1;
        tick;
        tick;
        mcmd = 3'b001; maddr = 32'h0; mdata = 32'h01;
        tick;
        mcmd = 3'b000;
        tick;
        irq[0] = 1'b0;
        rd_chk("edge_set_wins", 4'h0, 32'h01);

        // bus stress: three back-to-back commands
        do_reset;
        mcmd = 3'b001; maddr = 32'h4; mdata = 32'hFF;
        tick;
        check("b2b_resp0", {30'd0, sresp}, 32'd1);
        check("b2b_data0", sdata, 32'd0);
        mcmd = 3'b010; maddr = 32'h4;
        tick;
        check("b2b_resp1", {30'd0, sresp}, 32'd1);
        check("b2b_data1", sdata, 32'hFF);
        mcmd = 3'b010; maddr = 32'hC;
        tick;
        check("b2b_resp2", {30'd0, sresp}, 32'd1);
        check("b2b_data2", sdata, 32'd0);
        mcmd = 3'b000;
        tick;
        check("b2b_resp3", {30'd0, sresp}, 32'd0);

        // mid-operation asynchronous reset
        do_reset;
        wr(4'h8, 32'h01);
        wr(4'h4, 32'h01);
        irq[0] = 1'b1;
        repeat (4) tick;
        check("mid_intr_before", {31'd0, intr}, 32'd1);
        mcmd = 3'b010; maddr = 32'h0;
        tick;
        check("mid_resp_before", {30'd0, sresp}, 32'd1);
        nrst = 1'b0;
        mcmd = 3'b000;
        irq  = '0;
        #1;
        check("mid_intr_async", {31'd0, intr}, 32'd0);
        check("mid_resp_async", {30'd0, sresp}, 32'd0);
        tick;
        tick;
        nrst = 1'b1;
        tick;
        rd_chk("mid_pend", 4'h0, 32'h0);
        rd_chk("mid_mask", 4'h4, 32'h0);
        rd_chk("mid_edge", 4'h8, 32'h0);
        rd_chk("mid_vec", 4'hC, 32'h0);

        // randomized run against the reference model
        do_reset;
        m_pend = '0; m_mask = '0; m_edge = '0;
        hist = {8'h00, 8'h00, 8'h00};
        for (int c = 0; c < 600; c++) begin
            bit [7:0]  level, rise, clr, nxt;
            bit [1:0]  sel;
            bit        is_wr, is_rd, exp_intr;
            bit [31:0] exp_data;
            int        r;
            if ($urandom_range(0, 3) == 0) irq = irq ^ 8'($urandom);
            r = $urandom_range(0, 9);
            mcmd  = (r < 4) ? 3'b000 : (r < 7) ? 3'b010 : (r < 9) ? 3'b001
                  : 3'($urandom_range(3, 7));
            maddr = $urandom;
            mdata = $urandom;
            #1;
            is_wr = (mcmd == 3'b001);
            is_rd = (mcmd == 3'b010);
            sel   = maddr[3:2];
            check("rnd_accept", {31'd0, accept}, {31'd0, (is_wr | is_rd)});
            exp_intr = ((m_pend & m_mask) != 8'd0);
            exp_data = is_rd ? model_read(sel) : 32'd0;
            level = hist[1];
            rise  = hist[1] & ~hist[2];
            clr   = (is_wr && sel == 2'd0) ? mdata[7:0] : 8'd0;
            for (int i = 0; i < N; i++)
                nxt[i] = m_edge[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : level[i];
            m_pend = nxt;
            if (is_wr && sel == 2'd1) m_mask = mdata[7:0];
            if (is_wr && sel == 2'd2) m_edge = mdata[7:0];
            hist.push_front(irq);
            void'(hist.pop_back());
            tick;
            check("rnd_intr", {31'd0, intr}, {31'd0, exp_intr});
            check("rnd_resp", {30'd0, sresp}, {30'd0, 1'b0, (is_wr | is_rd)});
            check("rnd_sdata", sdata, exp_data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
